// File: rtl/i2s_master_tx.sv
// rtl/i2s_master_tx.sv - I2S bus master: derives BCLK/LRCLK from clk and shifts stereo samples out MSB-first
// Standard I2S framing: the MSB follows the LRCLK edge by one BCLK. Inputs pass through a one-deep pending buffer.
module i2s_master_tx #(
  parameter int BITSIZE  = 16,
  parameter int SLOT     = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] left_chan,
  input  logic [BITSIZE-1:0] right_chan,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               frame_strobe,
  output logic               underrun
);

  localparam int FRAME = 2 * SLOT;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [BW-1:0]      LAST_BIT = BW'(FRAME - 1);
  localparam logic [BW-1:0]      SLOT_B   = BW'(SLOT);
  localparam logic [BW-1:0]      BITS_B   = BW'(BITSIZE);
  localparam logic [DW-1:0]      DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BITSIZE-1:0] ONE      = BITSIZE'(1);

  logic [DW-1:0]      div_cnt_q, div_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic               strobe_q, strobe_d;
  logic               under_q, under_d;
  logic               ready_q, ready_d;
  logic               pend_full_q, pend_full_d;
  logic [BITSIZE-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [BITSIZE-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

  logic               fall, load, accept, right_slot;
  logic [BW-1:0]      nxt_bit, pos, shift;
  logic [BITSIZE-1:0] ch;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    bclk_d      = bclk_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    fall    = (div_cnt_q == DIV_LAST) && bclk_q;
    nxt_bit = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    load    = fall && (nxt_bit == '0);
    accept  = in_valid && ready_q;

    strobe_d = load;
    under_d  = load && !pend_full_q;

    if (load) begin
      act_l_d     = pend_full_q ? pend_l_q : '0;
      act_r_d     = pend_full_q ? pend_r_q : '0;
      pend_full_d = 1'b0;
    end

    // An accept coinciding with a load lands in pending, so it waits for the next frame.
    if (accept) begin
      pend_l_d    = left_chan;
      pend_r_d    = right_chan;
      pend_full_d = 1'b1;
    end
    ready_d = !pend_full_d;

    right_slot = (nxt_bit >= SLOT_B);
    pos        = right_slot ? (nxt_bit - SLOT_B) : nxt_bit;
    ch         = right_slot ? act_r_d : act_l_d;
    shift      = BITS_B - pos;

    if (fall) begin
      bit_cnt_d = nxt_bit;
      lrclk_d   = right_slot;
      sdata_d   = (pos != '0) && (pos <= BITS_B) && (|(ch & (ONE << shift)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= LAST_BIT;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
      ready_q     <= 1'b0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
      ready_q     <= ready_d;
      pend_full_q <= pend_full_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
    end
  end

  assign in_ready     = ready_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_strobe = strobe_q;
  assign underrun     = under_q;

endmodule
